// File: rtl/dense_layer_seq.sv
// Sequential dense layer: one MAC per input element, all neurons in parallel.
// Weights stream from an external 1-cycle-latency ROM; output is ReLU/saturated.
module dense_layer_seq #(
    parameter int IN_SIZE  = 32,
    parameter int OUT_SIZE = 3,
    parameter int IN_W     = 16,
    parameter int WB_W     = 8,
    parameter int ACC_W    = 32,
    parameter int OUT_W    = 16,
    parameter int SHIFT    = 0,
    parameter int RELU_EN  = 1,
    localparam int AW      = (IN_SIZE > 1) ? $clog2(IN_SIZE) : 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [IN_SIZE*IN_W-1:0]    in_vec,
    input  logic [OUT_SIZE*WB_W-1:0]   bias,
    output logic [AW-1:0]              w_addr,
    output logic                       w_rd,
    input  logic [OUT_SIZE*WB_W-1:0]   w_row,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [OUT_SIZE*OUT_W-1:0]  out_vec
);

    localparam int CW = $clog2(IN_SIZE + 1);

    if (ACC_W < IN_W + WB_W + $clog2(IN_SIZE) + 1) begin : g_acc_chk
        $error("dense_layer_seq: ACC_W too small for IN_W/WB_W/IN_SIZE");
    end
    if (SHIFT < 0 || SHIFT >= ACC_W) begin : g_shift_chk
        $error("dense_layer_seq: SHIFT out of range");
    end
    if (IN_SIZE < 1 || OUT_SIZE < 1) begin : g_size_chk
        $error("dense_layer_seq: IN_SIZE and OUT_SIZE must be >= 1");
    end

    typedef enum logic [1:0] {
        S_IDLE,
        S_MAC,
        S_ACT,
        S_OUT
    } state_t;

    state_t                   state_q, state_d;
    logic                     accept;
    logic                     act;
    logic [CW-1:0]            idx_q;
    logic [AW-1:0]            addr_q;
    logic [AW-1:0]            raddr_q;
    logic                     pend_q;
    logic signed [IN_W-1:0]   vec_q [IN_SIZE];
    logic signed [ACC_W-1:0]  acc_q [OUT_SIZE];
    logic signed [ACC_W-1:0]  prod  [OUT_SIZE];
    logic signed [OUT_W-1:0]  out_q [OUT_SIZE];
    logic signed [OUT_W-1:0]  res_d [OUT_SIZE];

    // State register
    always_ff @(posedge clk) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    // Next-state logic and handshake/ROM strobes
    always_comb begin
        state_d   = state_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        w_rd      = 1'b0;
        accept    = 1'b0;
        act       = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    accept  = 1'b1;
                    state_d = S_MAC;
                end
            end
            S_MAC: begin
                w_rd = (idx_q < CW'(IN_SIZE));
                if (idx_q == CW'(IN_SIZE)) state_d = S_ACT;
            end
            S_ACT: begin
                act     = 1'b1;
                state_d = S_OUT;
            end
            S_OUT: begin
                out_valid = 1'b1;
                if (out_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign w_addr = addr_q;

    // Products for the weight row returned this cycle
    always_comb begin
        for (int j = 0; j < OUT_SIZE; j++) begin
            prod[j] = ACC_W'(vec_q[raddr_q])
                    * ACC_W'($signed(w_row[j*WB_W +: WB_W]));
        end
    end

    // Shift, optional ReLU and saturation per neuron
    for (genvar j = 0; j < OUT_SIZE; j++) begin : g_act
        logic signed [ACC_W-1:0] sh;
        logic signed [ACC_W-1:0] rl;
        assign sh = acc_q[j] >>> SHIFT;
        assign rl = (RELU_EN != 0 && sh[ACC_W-1]) ? '0 : sh;
        if (OUT_W >= ACC_W) begin : g_wide
            assign res_d[j] = OUT_W'(rl);
        end else begin : g_sat
            localparam logic signed [ACC_W-1:0] OMAX =
                {{(ACC_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
            localparam logic signed [ACC_W-1:0] OMIN =
                {{(ACC_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};
            assign res_d[j] = (rl > OMAX) ? OMAX[OUT_W-1:0]
                            : (rl < OMIN) ? OMIN[OUT_W-1:0]
                            : rl[OUT_W-1:0];
        end
        assign out_vec[j*OUT_W +: OUT_W] = out_q[j];
    end

    // Datapath: capture, address issue, accumulate, result register
    always_ff @(posedge clk) begin
        if (rst) begin
            idx_q   <= '0;
            addr_q  <= '0;
            raddr_q <= '0;
            pend_q  <= 1'b0;
            for (int k = 0; k < IN_SIZE; k++) vec_q[k] <= '0;
            for (int j = 0; j < OUT_SIZE; j++) begin
                acc_q[j] <= '0;
                out_q[j] <= '0;
            end
        end else begin
            pend_q  <= w_rd;
            raddr_q <= addr_q;
            if (accept) begin
                idx_q  <= '0;
                addr_q <= '0;
                for (int k = 0; k < IN_SIZE; k++) begin
                    vec_q[k] <= in_vec[k*IN_W +: IN_W];
                end
                for (int j = 0; j < OUT_SIZE; j++) begin
                    acc_q[j] <= ACC_W'($signed(bias[j*WB_W +: WB_W]));
                end
            end else begin
                if (state_q == S_MAC) idx_q <= idx_q + CW'(1);
                if (w_rd && addr_q != AW'(IN_SIZE - 1)) begin
                    addr_q <= addr_q + AW'(1);
                end
                if (pend_q) begin
                    for (int j = 0; j < OUT_SIZE; j++) begin
                        acc_q[j] <= acc_q[j] + prod[j];
                    end
                end
            end
            if (act) begin
                for (int j = 0; j < OUT_SIZE; j++) out_q[j] <= res_d[j];
            end
        end
    end

endmodule

// File: tb/tb_dense_layer_seq.sv
// Bench for dense_layer_seq: three instances in lockstep (ReLU, linear,
// shifted single-neuron), table vectors, corner sequences, random vs model.
module tb_dense_layer_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        out_ready;
    logic [31:0] in_vec_s;
    logic [15:0] bias_s;

    logic        rdy_a, rdy_b, rdy_c;
    logic [1:0]  wa_a, wa_b, wa_c;
    logic        rd_a, rd_b, rd_c;
    logic [15:0] row_a, row_b;
    logic [7:0]  row_c;
    logic        ov_a, ov_b, ov_c;
    logic [15:0] out_a, out_b;
    logic [7:0]  out_c;

    logic signed [7:0] wmem [4][2];
    logic [31:0] cur_x;
    logic [15:0] cur_b;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    dense_layer_seq #(.IN_SIZE(4), .OUT_SIZE(2), .IN_W(8), .WB_W(8),
        .ACC_W(32), .OUT_W(8), .SHIFT(0), .RELU_EN(1)) u_a (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy_a),
        .in_vec(in_vec_s), .bias(bias_s), .w_addr(wa_a), .w_rd(rd_a),
        .w_row(row_a), .out_valid(ov_a), .out_ready(out_ready),
        .out_vec(out_a));

    dense_layer_seq #(.IN_SIZE(4), .OUT_SIZE(2), .IN_W(8), .WB_W(8),
        .ACC_W(32), .OUT_W(8), .SHIFT(0), .RELU_EN(0)) u_b (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy_b),
        .in_vec(in_vec_s), .bias(bias_s), .w_addr(wa_b), .w_rd(rd_b),
        .w_row(row_b), .out_valid(ov_b), .out_ready(out_ready),
        .out_vec(out_b));

    dense_layer_seq #(.IN_SIZE(4), .OUT_SIZE(1), .IN_W(8), .WB_W(8),
        .ACC_W(32), .OUT_W(8), .SHIFT(2), .RELU_EN(0)) u_c (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy_c),
        .in_vec(in_vec_s), .bias(bias_s[7:0]), .w_addr(wa_c), .w_rd(rd_c),
        .w_row(row_c), .out_valid(ov_c), .out_ready(out_ready),
        .out_vec(out_c));

    // Weight ROMs: one cycle read latency, garbage when not read
    always @(posedge clk) begin
        if (rd_a) row_a <= {wmem[wa_a][1], wmem[wa_a][0]};
        else      row_a <= 16'($urandom);
        if (rd_b) row_b <= {wmem[wa_b][1], wmem[wa_b][0]};
        else      row_b <= 16'($urandom);
        if (rd_c) row_c <= wmem[wa_c][0];
        else      row_c <= 8'($urandom);
    end

    task automatic chk(input string nm, input logic signed [63:0] got,
                       input logic signed [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, required %0d", nm, got, exp);
        end
    endtask

    function automatic int sel8(input logic [15:0] v, input int j);
        return int'($signed(v[j*8 +: 8]));
    endfunction

    // Reference: bias + dot product, floor shift, ReLU, clamp to 8 bits
    function automatic int ref_out(input int shift, input bit relu,
                                   input int j);
        longint acc;
        acc = longint'($signed(cur_b[j*8 +: 8]));
        for (int k = 0; k < 4; k++) begin
            acc += longint'($signed(cur_x[k*8 +: 8])) * longint'(wmem[k][j]);
        end
        acc = acc >>> shift;
        if (relu && acc < 0) acc = 0;
        if (acc > 127) acc = 127;
        if (acc < -128) acc = -128;
        return int'(acc);
    endfunction

    task automatic chk_outs(input string tag, input int ea0, input int ea1,
                            input int eb0, input int eb1, input int ec);
        chk({tag, " a0"}, sel8(out_a, 0), ea0);
        chk({tag, " a1"}, sel8(out_a, 1), ea1);
        chk({tag, " b0"}, sel8(out_b, 0), eb0);
        chk({tag, " b1"}, sel8(out_b, 1), eb1);
        chk({tag, " c"}, int'($signed(out_c)), ec);
    endtask

    // Drive one vector (called at a negedge with the DUTs idle)
    task automatic do_vec(input int ea0, input int ea1, input int eb0,
                          input int eb1, input int ec, input int hold,
                          input int abort_at);
        int lat;
        in_vec_s = cur_x;
        bias_s   = cur_b;
        in_valid = 1'b1;
        chk("accept rdy", rdy_a, 1);
        @(negedge clk);
        in_vec_s = $urandom;
        bias_s   = 16'($urandom);
        lat = 1;
        while (lat < 40) begin
            if (lat == abort_at) begin
                rst = 1'b1;
                in_valid = 1'b0;
                @(negedge clk);
                rst = 1'b0;
                chk("abort in_ready", rdy_a, 1);
                chk("abort out_valid", ov_a, 0);
                chk("abort w_rd", rd_a, 0);
                chk("abort w_addr", wa_a, 0);
                chk("abort out_vec", out_a, 0);
                return;
            end
            if (lat <= 5) chk("w_rd seq", rd_a, (lat <= 4) ? 1 : 0);
            if (lat <= 4) chk("w_addr seq", wa_a, lat - 1);
            if (ov_a) break;
            chk("busy in_ready", rdy_a | rdy_b | rdy_c, 0);
            @(negedge clk);
            lat++;
        end
        chk("latency", lat, 7);
        chk("valid b", ov_b, 1);
        chk("valid c", ov_c, 1);
        chk_outs("result", ea0, ea1, eb0, eb1, ec);
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            chk("hold valid", ov_a & ov_b & ov_c, 1);
            chk("hold in_ready", rdy_a | rdy_b | rdy_c, 0);
            chk_outs("hold", ea0, ea1, eb0, eb1, ec);
        end
        out_ready = 1'b1;
        in_valid  = 1'b0;
        @(negedge clk);
        out_ready = 1'b0;
        chk("post valid", ov_a | ov_b | ov_c, 0);
        chk("post in_ready", rdy_a & rdy_b & rdy_c, 1);
    endtask

    typedef struct packed {
        int x0, x1, x2, x3;
        int w0, w1;
        int b0, b1;
        int ea0, ea1, eb0, eb1, ec;
        int hold;
    } vec_t;

    task automatic load(input vec_t t);
        cur_x = {8'(t.x3), 8'(t.x2), 8'(t.x1), 8'(t.x0)};
        cur_b = {8'(t.b1), 8'(t.b0)};
        for (int k = 0; k < 4; k++) begin
            wmem[k][0] = 8'(t.w0);
            wmem[k][1] = 8'(t.w1);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        vec_t tbl [6];
        tbl[0] = '{1, 2, 3, 4, 1, 1, 0, -20, 10, 0, 10, -10, 2, 0};
        tbl[1] = '{127, 127, 127, 127, 127, -127, 0, 0,
                   127, 0, 127, -128, 127, 5};
        tbl[2] = '{0, 0, 0, 0, 1, 1, 13, -13, 13, 0, 13, -13, 3, 1};
        tbl[3] = '{0, 0, 0, 0, 1, 1, -13, 5, 0, 5, -13, 5, -4, 0};
        tbl[4] = '{-128, -128, -128, -128, 127, -128, 0, 0,
                   0, 127, -128, 127, -128, 2};
        tbl[5] = '{-1, 2, -3, 4, 2, -3, 7, -1, 11, 0, 11, -7, 2, 0};

        rst = 1'b1;
        in_valid = 1'b1;
        out_ready = 1'b1;
        in_vec_s = '0;
        bias_s = '0;
        load(tbl[0]);
        repeat (3) @(negedge clk);
        chk("rst prio w_rd", rd_a | rd_b | rd_c, 0);
        rst = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b0;
        chk("reset in_ready", rdy_a & rdy_b & rdy_c, 1);
        chk("reset out_valid", ov_a | ov_b | ov_c, 0);
        chk("reset w_addr", wa_a, 0);
        chk_outs("reset", 0, 0, 0, 0, 0);

        for (int i = 0; i < 6; i++) begin
            load(tbl[i]);
            do_vec(tbl[i].ea0, tbl[i].ea1, tbl[i].eb0, tbl[i].eb1,
                   tbl[i].ec, tbl[i].hold, 0);
        end

        load(tbl[5]);
        do_vec(0, 0, 0, 0, 0, 0, 2);
        load(tbl[0]);
        do_vec(tbl[0].ea0, tbl[0].ea1, tbl[0].eb0, tbl[0].eb1,
               tbl[0].ec, 0, 0);

        for (int i = 0; i < 30; i++) begin
            cur_x = $urandom;
            cur_b = 16'($urandom);
            for (int k = 0; k < 4; k++) begin
                wmem[k][0] = 8'($urandom);
                wmem[k][1] = 8'($urandom);
            end
            do_vec(ref_out(0, 1'b1, 0), ref_out(0, 1'b1, 1),
                   ref_out(0, 1'b0, 0), ref_out(0, 1'b0, 1),
                   ref_out(2, 1'b0, 0), int'($urandom_range(0, 3)), 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/dense_layer_seq.md
DENSE_LAYER_SEQ -- requirements
Module: dense_layer_seq

Interface
REQ-001 Parameter IN_SIZE, 32: input vector length, number of MAC steps; >= 1.
REQ-002 Parameter OUT_SIZE, 3: output neuron count, processed in parallel; >= 1.
REQ-003 Parameter IN_W, 16: signed input element width.
REQ-004 Parameter WB_W, 8: signed weight and bias width.
REQ-005 Parameter ACC_W, 32: signed accumulator width; elaboration error unless ACC_W >= IN_W+WB_W+clog2(IN_SIZE)+1.
REQ-006 Parameter OUT_W, 16: signed output element width.
REQ-007 Parameter SHIFT, 0: arithmetic right shift applied after accumulation, range 0..ACC_W-1.
REQ-008 Parameter RELU_EN, 1: 1 = ReLU applied, 0 = linear output.
REQ-009 clk  in  1  clock; all state updates on rising edge.
REQ-010 rst  in  1  reset, synchronous, active-high.
REQ-011 in_valid  in  1  input vector and bias valid.
REQ-012 in_ready  out  1  block can accept a vector.
REQ-013 in_vec  in  IN_SIZE x IN_W signed  input vector, sampled on accept.
REQ-014 bias  in  OUT_SIZE x WB_W signed  bias per neuron, sampled on accept.
REQ-015 w_addr  out  clog2(IN_SIZE) (min 1)  weight-row address to external ROM.
REQ-016 w_rd  out  1  weight-row read strobe.
REQ-017 w_row  in  OUT_SIZE x WB_W signed  weight row for address issued in previous cycle (read latency exactly 1).
REQ-018 out_valid  out  1  output vector valid.
REQ-019 out_ready  in  1  downstream accepts output.
REQ-020 out_vec  out  OUT_SIZE x OUT_W signed  result vector.

Function
REQ-021 FSM states IDLE, MAC, ACT, OUT; in_ready = 1 only in IDLE.
REQ-022 IDLE: on in_valid & in_ready, register in_vec, load acc[j] = sign-extended bias[j], clear idx, go MAC.
REQ-023 MAC: w_rd = 1 and w_addr = idx for idx = 0..IN_SIZE-1 on consecutive cycles; w_rd = 0 and w_addr held outside MAC.
REQ-024 MAC: the cycle after address k is issued, acc[j] += in_vec[k] * w_row[j], full-precision signed product, sign-extended to ACC_W.
REQ-025 MAC lasts IN_SIZE+1 cycles (issue/accumulate pipeline including drain), then go ACT.
REQ-026 ACT (1 cycle): r = acc[j] >>> SHIFT; if RELU_EN and r < 0 then r = 0; saturate r to [-2^(OUT_W-1), 2^(OUT_W-1)-1]; register into out_vec; go OUT.
REQ-027 Latency: out_valid first high exactly IN_SIZE+3 cycles after the accepting edge.
REQ-028 OUT: out_valid = 1 and out_vec stable until out_valid & out_ready; then go IDLE.
REQ-029 One vector in flight; no input accepted in MAC/ACT/OUT; earliest next accept one cycle after the output handshake.
REQ-030 in_vec and bias changes after accept have no effect on the current result.
REQ-031 Accumulator never wraps, guaranteed by REQ-005; saturation applies only in ACT.

Reset
REQ-032 rst forces IDLE, idx = 0, acc = 0, out_vec = 0, out_valid = 0, w_rd = 0, w_addr = 0; in_ready = 1 in the first cycle after rst deasserts.
REQ-033 rst in any state aborts the computation; the partial result is never presented.
REQ-034 rst has priority over in_valid and out_ready in the same cycle.

Verification
REQ-035 IN_SIZE=4, OUT_SIZE=2, in_vec {1,2,3,4}, all weights 1, bias {0,-20}, RELU_EN=1 -> out_vec {10,0}; out_valid at accept+7.
REQ-036 Same stimulus with RELU_EN=0 -> out_vec {10,-10}.
REQ-037 OUT_W=8, IN_W=8, IN_SIZE=4, in_vec all 127, weights {127,-127}, bias 0, RELU_EN=0 -> out_vec {127,-128} (saturated).
REQ-038 SHIFT=2, single neuron, acc = 13 -> out 3; acc = -13, RELU_EN=0 -> out -4.
REQ-039 out_ready low 5 cycles after out_valid -> out_vec and out_valid held, in_ready = 0, in_valid ignored; accept occurs only after the handshake.
REQ-040 rst pulsed on MAC cycle 2 -> next cycle IDLE, out_valid = 0, w_rd = 0; fresh vector then gives the correct result with full latency.
